apb_dp_mem_cfg: RTL

//  Parametrised APB4 slave memory: byte-strobed writes, configurable read/write wait states and depth.

---
 rtl/apb_dp_mem_cfg_pkg.sv | 7 +
 rtl/apb_dp_mem_cfg_ram.sv | 45 ++++
 rtl/apb_dp_mem_cfg.sv | 104 ++++++++++
 3 files changed

// File: rtl/apb_dp_mem_cfg_pkg.sv
// apb_dp_mem_cfg_pkg: shared types and limits for the APB slave memory
//   apb_mem_state_t : slave FSM states (IDLE, ACCESS)
//   APB_MAX_WAIT    : largest wait-state count the 4-bit counter can hold
package apb_dp_mem_cfg_pkg;
    typedef enum logic {IDLE, ACCESS} apb_mem_state_t;
    localparam int APB_MAX_WAIT = 15;
endpackage

// File: rtl/apb_dp_mem_cfg_ram.sv
// apb_dp_ram: DEPTH x DW storage, one byte-strobed write port, two registered read ports
//   clk, rst                   : clock, sync active-high reset (clears read registers only)
//   we, w_addr, w_strb, w_data : write port, lanes with w_strb[i]=1 updated
//   a_en, a_zero, a_addr       : APB capture port; a_zero forces a zero capture
//   a_data                     : APB capture register
//   b_en, b_addr, b_data       : port-B read, 1-cycle latency, held while !b_en
module apb_dp_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   w_addr,
    input  logic [DW/8-1:0] w_strb,
    input  logic [DW-1:0]   w_data,
    input  logic            a_en,
    input  logic            a_zero,
    input  logic [AW-1:0]   a_addr,
    output logic [DW-1:0]   a_data,
    input  logic            b_en,
    input  logic [AW-1:0]   b_addr,
    output logic [DW-1:0]   b_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < DW/8; i++)
                if (w_strb[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
    end

    // Reads sample the array before this edge's write lands, so a colliding
    // port-B read returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_en) a_data <= (a_zero || 32'(a_addr) >= DEPTH) ? '0 : mem[a_addr];
            if (b_en) b_data <= (32'(b_addr) >= DEPTH) ? '0 : mem[b_addr];
        end
    end
endmodule

// File: rtl/apb_dp_mem_cfg.sv
// apb_dp_mem_cfg: APB4 slave memory with wait states, error decode and a read-only port B
//   PCLK, PRESET                       : clock, sync active-high reset
//   PSEL, PENABLE, PWRITE, PADDR       : APB control and byte address
//   PWDATA, PSTRB, PPROT               : write data, byte lanes, protection (bit 0 privileged)
//   PRDATA, PREADY, PSLVERR            : APB response
//   b_en, b_addr, b_data               : port-B word read, 1-cycle latency
module apb_dp_mem_cfg
    import apb_dp_mem_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 3,
    parameter int PROT_WORDS = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    input  logic [2:0]                   PPROT,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic                         b_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] b_addr,
    output logic [DATA_WIDTH-1:0]        b_data
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);

    if (RD_WAIT < 0 || RD_WAIT > APB_MAX_WAIT || WR_WAIT < 0 || WR_WAIT > APB_MAX_WAIT) begin : g_bad_wait
        $error("apb_dp_mem_cfg: RD_WAIT and WR_WAIT must lie in 0..15");
    end

    apb_mem_state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic err_q, err, cap, we;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic unused_prot;

    assign unused_prot = ^PPROT[2:1];
    assign idx = PADDR >> OB;
    assign err = 32'(idx) >= MEM_DEPTH
              || (PADDR % ADDR_WIDTH'(NB)) != '0
              || (!PWRITE && |PSTRB)
              || (PWRITE && 32'(idx) < PROT_WORDS && !PPROT[0]);

    // A setup phase seen while idle, or in the completion cycle, starts a new transfer.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap     = 1'b0;
        if (state == IDLE) cap = PSEL && !PENABLE;
        else if (!PSEL) state_d = IDLE;
        else if (cnt != '0) cnt_d = cnt - 4'd1;
        else if (!PENABLE) cap = 1'b1;
        else state_d = IDLE;
        if (cap) begin
            state_d = ACCESS;
            cnt_d   = PWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (cap) err_q <= err;
        end
    end

    assign PREADY  = state == ACCESS && cnt == '0;
    assign PSLVERR = PREADY & err_q;
    assign PRDATA  = (PREADY && !PWRITE) ? rdata_q : '0;
    // Reset on the completion edge drops the write.
    assign we = PREADY && PSEL && PENABLE && PWRITE && !err_q && !PRESET;

    apb_dp_ram #(.DEPTH(MEM_DEPTH), .DW(DATA_WIDTH), .AW(AW)) u_ram (
        .clk    (PCLK),
        .rst    (PRESET),
        .we     (we),
        .w_addr (AW'(idx)),
        .w_strb (PSTRB),
        .w_data (PWDATA),
        .a_en   (cap),
        .a_zero (err),
        .a_addr (AW'(idx)),
        .a_data (rdata_q),
        .b_en   (b_en),
        .b_addr (b_addr),
        .b_data (b_data)
    );
endmodule
